fpc_rx_ctrl: RTL and testbench
==============================

FPC_RX_CTRL -- requirements
Module: fpc_rx_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, output FIFO entries; power of two, 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 Port: flush  input  1  synchronous clear of the partial byte and FIFO; counter kept.
REQ-005 Port: data_in  input  5  FPC codeword from the crosstalk-avoiding bus.
REQ-006 Port: in_valid  input  1  data_in holds a codeword.
REQ-007 Port: in_ready  output  1  block accepts data_in this cycle.
REQ-008 Port: data_out  output  8  decoded byte at FIFO head.
REQ-009 Port: err_out  output  1  error flag of FIFO head byte.
REQ-010 Port: out_valid  output  1  FIFO head valid.
REQ-011 Port: out_ready  input  1  consumer takes head this cycle.
REQ-012 Port: err_cnt  output  8  saturating count of error bytes written to FIFO.

Function
REQ-013 Codeword-to-nibble table SHALL be: 00000-0, 00001-1, 00110-2, 00011-3, 01100-4, 00111-5, 01110-6, 01111-7, 10000-8, 10001-9, 11000-A, 10011-B, 11100-C, 11001-D, 11110-E, 11111-F.
REQ-014 Any other codeword SHALL decode to nibble 0 and mark the nibble invalid.
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-016 FSM SHALL have two states: S_HI (expect high nibble) and S_LO (expect low nibble).
REQ-017 S_HI transfer: decoded nibble and invalid flag go to holding register; move to S_LO; no FIFO write.
REQ-018 S_LO transfer: write {hold_nibble, new_nibble} with err = hold_invalid OR new_invalid to FIFO; return to S_HI.
REQ-019 in_ready SHALL be 1 in S_HI; in S_LO, in_ready = FIFO not full (registered full flag, no pop pass-through).
REQ-020 out_valid = FIFO not empty; data_out and err_out = head entry, both 0 when empty.
REQ-021 Pop SHALL occur when out_valid and out_ready are both 1; simultaneous push and pop keeps occupancy unchanged.
REQ-022 Latency: byte SHALL appear on out_valid the cycle after the low-nibble transfer, when the FIFO was empty.
REQ-023 Pointers SHALL wrap modulo DEPTH; occupancy counter 0..DEPTH drives full/empty.
REQ-024 err_cnt SHALL increment by 1 per FIFO write with err=1 and hold at 255.
REQ-025 flush=1 SHALL force S_HI, clear the holding register, and empty the FIFO next cycle; a same-cycle input transfer and pop SHALL be discarded; err_cnt unchanged.
REQ-026 in_ready SHALL be 0 during flush=1.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set state S_HI, FIFO empty, pointers 0, holding register 0, err_cnt 0.
REQ-028 Outputs after reset: out_valid 0, data_out 0x00, err_out 0, in_ready 1, err_cnt 0.
REQ-029 Reset mid-byte (state S_LO) SHALL discard the held nibble with no FIFO write.
REQ-030 Reset SHALL override flush and all handshakes in the same cycle.

Verification
REQ-031 Send 00110 then 11110, out_ready=1 -> one cycle later out_valid=1, data_out=0x2E, err_out=0, err_cnt=0.
REQ-032 Send 00010 then 00001 -> data_out=0x01, err_out=1, err_cnt=1; 300 such bytes -> err_cnt=255 (saturated).
REQ-033 out_ready=0, send 2*DEPTH+1 codewords -> DEPTH bytes stored, in_ready=0 in S_LO; raise out_ready -> bytes drain in order, none lost or duplicated.
REQ-034 FIFO full with out_ready=1 and a low-nibble offered -> pop this cycle, in_ready still 0, byte accepted next cycle.
REQ-035 Send 10000, then flush=1 with in_valid=1 -> no byte output; next pair 11111,11111 -> data_out=0xFF.
REQ-036 Send 11100, then rst_n=0 for one cycle -> FIFO empty; send 00001,10001 -> data_out=0x19, err_cnt=0.

Source files
------------

// File: rtl/fpc_rx_ctrl.sv
// -----------------------------------------------------------------------------
// fpc_rx_ctrl
//
// Receive-side controller for a 5-bit Fibonacci-style crosstalk-avoiding (FPC)
// bus. Codewords are decoded to nibbles, pairs of nibbles (high first) are
// packed into bytes, and each byte is queued together with an error flag in a
// small output FIFO. A saturating counter tracks how many erroneous bytes
// have been queued.
//
// Parameters
//   DEPTH      output FIFO entries, power of two in 2..16
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      synchronous clear of partial byte and FIFO (err_cnt kept)
//   data_in    FPC codeword
//   in_valid   data_in holds a codeword
//   in_ready   codeword accepted this cycle when in_valid is also high
//   data_out   decoded byte at FIFO head (0 when empty)
//   err_out    error flag of FIFO head byte (0 when empty)
//   out_valid  FIFO holds at least one byte
//   out_ready  consumer takes the head byte this cycle
//   err_cnt    saturating count of error bytes written to the FIFO
// -----------------------------------------------------------------------------
module fpc_rx_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [4:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] data_out,
    output logic       err_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_HI,   // next codeword carries the high nibble
        S_LO    // next codeword carries the low nibble
    } state_t;

    // Returns {invalid, nibble}; codewords outside the table decode to 0.
    function automatic logic [4:0] decode(input logic [4:0] cw);
        logic [4:0] res;
        case (cw)
            5'b00000: res = {1'b0, 4'h0};
            5'b00001: res = {1'b0, 4'h1};
            5'b00110: res = {1'b0, 4'h2};
            5'b00011: res = {1'b0, 4'h3};
            5'b01100: res = {1'b0, 4'h4};
            5'b00111: res = {1'b0, 4'h5};
            5'b01110: res = {1'b0, 4'h6};
            5'b01111: res = {1'b0, 4'h7};
            5'b10000: res = {1'b0, 4'h8};
            5'b10001: res = {1'b0, 4'h9};
            5'b11000: res = {1'b0, 4'hA};
            5'b10011: res = {1'b0, 4'hB};
            5'b11100: res = {1'b0, 4'hC};
            5'b11001: res = {1'b0, 4'hD};
            5'b11110: res = {1'b0, 4'hE};
            5'b11111: res = {1'b0, 4'hF};
            default:  res = {1'b1, 4'h0};
        endcase
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         hold_nibble;
    logic               hold_invalid;
    logic [8:0]         mem [DEPTH];     // {err, byte}
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [4:0]         dec;
    logic               new_invalid;
    logic [3:0]         new_nibble;
    logic               byte_err;
    logic               full;
    logic               in_fire;
    logic               push;
    logic               pop;

    assign dec         = decode(data_in);
    assign new_invalid = dec[4];
    assign new_nibble  = dec[3:0];
    assign byte_err    = hold_invalid | new_invalid;

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign in_fire   = in_valid && in_ready;
    // A flush discards any pop offered in the same cycle.
    assign pop       = out_valid && out_ready && !flush;

    assign data_out  = out_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign err_out   = out_valid ? mem[rd_ptr][8]   : 1'b0;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_HI;
        end else if (in_fire) begin
            state_d = (state_q == S_HI) ? S_LO : S_HI;
        end
    end

    // in_ready looks at the registered full flag only: a pop in the same
    // cycle does not open the input, which keeps in_ready off the out_ready
    // path.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            in_ready = (state_q == S_HI) || !full;
        end
        push = in_valid && in_ready && (state_q == S_LO);
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_nibble  <= 4'h0;
            hold_invalid <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_cnt      <= 8'h00;
        end else if (flush) begin
            hold_nibble  <= 4'h0;
            hold_invalid <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            if (in_fire && (state_q == S_HI)) begin
                hold_nibble  <= new_nibble;
                hold_invalid <= new_invalid;
            end
            if (push) begin
                // Pointer width equals log2(DEPTH), so wrap is free.
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (byte_err && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; the occupancy counter marks every
    // entry stale and the outputs are gated to zero while empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= {byte_err, hold_nibble, new_nibble};
        end
    end

endmodule

// File: tb/tb_fpc_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpc_rx_ctrl
//
// Directed bench for fpc_rx_ctrl (DEPTH = 4). Stimulus pushes hand-computed
// {err, byte} values into a queue; a monitor on the falling edge pops and
// compares whenever the DUT hands over a byte. Inputs change 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_fpc_rx_ctrl;

    localparam int DEPTH = 4;

    // Codewords by nibble value
    localparam logic [4:0] CW0 = 5'b00000, CW1 = 5'b00001, CW2 = 5'b00110,
                           CW3 = 5'b00011, CW4 = 5'b01100, CW5 = 5'b00111,
                           CW6 = 5'b01110, CW7 = 5'b01111, CW8 = 5'b10000,
                           CW9 = 5'b10001, CWA = 5'b11000, CWC = 5'b11100,
                           CWE = 5'b11110, CWF = 5'b11111;
    localparam logic [4:0] CW_BAD = 5'b00010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] data_in = 5'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_out;
    logic       err_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] err_cnt;

    int         total = 0;
    int         bad = 0;
    logic [8:0] exp_q [$];
    logic [8:0] mon_exp;

    fpc_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handed-over byte must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && !flush && out_ready && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got 0x%0h with nothing expected",
                         {err_out, data_out});
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_byte", {23'b0, err_out, data_out}, {23'b0, mon_exp});
            end
        end
    end

    // Starts and ends 1 unit after a rising edge.
    task automatic send(input logic [4:0] cw);
        int   waits;
        logic acc;
        waits = 0;
        acc = 1'b0;
        data_in = cw;
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout: in_ready stayed 0 for cw 0x%0h", cw);
                    acc = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_byte(input logic err, input logic [7:0] b);
        exp_q.push_back({err, b});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out",  data_out,  8'h00);
        check("rst_err_out",   err_out,   0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_err_cnt",   err_cnt,   8'h00);

        // ---------------- basic byte and latency: 2,E -> 0x2E
        out_ready = 1'b1;
        expect_byte(1'b0, 8'h2E);
        send(CW2);
        check("hi_no_output", out_valid, 0);
        send(CWE);
        check("lat_out_valid", out_valid, 1);
        check("lat_data_out",  data_out,  8'h2E);
        check("lat_err_out",   err_out,   0);
        check("lat_err_cnt",   err_cnt,   8'h00);
        wait_drain("drain_basic");

        // ---------------- error bytes and err_cnt saturation
        for (int i = 0; i < 300; i++) begin
            expect_byte(1'b1, 8'h01);
            send(CW_BAD);
            send(CW1);
            if (i == 0)   check("err_cnt_1",   err_cnt, 8'd1);
            if (i == 253) check("err_cnt_254", err_cnt, 8'd254);
            if (i == 254) check("err_cnt_255", err_cnt, 8'd255);
        end
        check("err_cnt_sat", err_cnt, 8'd255);
        wait_drain("drain_err");

        // ---------------- fill FIFO with out_ready low, 2*DEPTH+1 codewords
        out_ready = 1'b0;
        expect_byte(1'b0, 8'h12); send(CW1); send(CW2);
        expect_byte(1'b0, 8'h34); send(CW3); send(CW4);
        expect_byte(1'b0, 8'h56); send(CW5); send(CW6);
        expect_byte(1'b0, 8'h78); send(CW7); send(CW8);
        send(CW9);
        expect_byte(1'b0, 8'h9A);
        data_in = CWA;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        check("full_out_valid", out_valid, 1);
        check("full_head",      data_out,  8'h12);
        // Pop while full: input stays blocked this cycle, opens the next.
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_no_passthru", in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_pop", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain("drain_fill");
        check("empty_after_drain", out_valid, 0);

        // ---------------- flush empties a non-empty FIFO
        out_ready = 1'b0;
        send(CW1);
        send(CW1);
        check("pre_flush_valid", out_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_empty",    out_valid, 0);
        check("flush_data_out", data_out,  8'h00);

        // ---------------- flush mid-byte with a codeword offered
        out_ready = 1'b1;
        send(CW8);
        flush = 1'b1;
        data_in = CWF;
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_mid_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_mid_no_byte", out_valid, 0);
        check("flush_err_cnt",     err_cnt,   8'd255);
        expect_byte(1'b0, 8'hFF);
        send(CWF);
        send(CWF);
        wait_drain("drain_flush");

        // ---------------- reset mid-byte
        send(CWC);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready",  in_ready,  1);
        check("rst_mid_err_cnt",   err_cnt,   8'h00);
        expect_byte(1'b0, 8'h19);
        send(CW1);
        send(CW9);
        check("rst_mid_data_out", data_out, 8'h19);
        wait_drain("drain_rst");
        check("final_err_cnt", err_cnt, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
